// File: rtl/tile_column_feeder_if.sv
// Row-beat input stream plus column/enable output bundle for the tile column feeder.
// slave = the feeder itself, master = the environment driving it.
interface tile_column_feeder_if #(
  parameter int N   = 4,
  parameter int D_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N*D_W-1:0] in_data;
  logic             stall;
  logic [N*D_W-1:0] out_data;
  logic             out_enable;
  logic             out_first;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, stall,
    input  in_ready, out_data, out_enable, out_first, out_last, busy, done
  );

  modport slave (
    input  in_valid, in_data, stall,
    output in_ready, out_data, out_enable, out_first, out_last, busy, done
  );
endinterface

// File: rtl/tile_column_feeder.sv
// Buffers an NxN tile row-by-row, replays it one column per cycle, then N-1 zero columns; DOUBLE_BUF_EN adds a shadow buffer.
// First column one cycle after the last row beat; stall freezes STREAM/FLUSH and drops out_enable; in_ready only in LOAD unless double-buffered.
module tile_column_feeder #(
  parameter int N   = 4,
  parameter int D_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tile_column_feeder_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = N * D_W;
`ifdef DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {LOAD, STREAM, FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   row_cnt;
  logic [CW-1:0]   col_cnt;
  logic [CW-1:0]   flush_cnt;
  logic [RW-1:0]   mem [NB][N];
  logic            rdy;
  logic            done_q;
  logic            act;
  logic            ld_sel;
  logic            accept;
  logic            last_beat;
  logic            tile_end;
  logic [RW-1:0]   col;

`ifdef DOUBLE_BUF_EN
  logic shadow_full;
  logic next_ready;
  assign ld_sel     = ~act;
  // A tile completing on this very beat still counts as ready for the swap.
  assign next_ready = shadow_full | last_beat;
`else
  assign act    = 1'b0;
  assign ld_sel = act;
`endif

  assign accept    = bus.in_valid & rdy;
  assign last_beat = accept & (row_cnt == CW'(N - 1));
  assign tile_end  = ~bus.stall &
                     (((state == FLUSH) && (flush_cnt == CW'(N - 2))) ||
                      ((state == STREAM) && (N == 1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      row_cnt   <= '0;
      col_cnt   <= '0;
      flush_cnt <= '0;
      rdy       <= 1'b0;
      done_q    <= 1'b0;
`ifdef DOUBLE_BUF_EN
      act         <= 1'b0;
      shadow_full <= 1'b0;
`endif
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < N; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mem[ld_sel][row_cnt] <= bus.in_data;
        row_cnt              <= last_beat ? '0 : row_cnt + 1'b1;
      end

      case (state)
        LOAD: begin
`ifdef DOUBLE_BUF_EN
          rdy <= 1'b1;
`else
          rdy <= ~last_beat;
`endif
          if (last_beat) begin
            state   <= STREAM;
            col_cnt <= '0;
`ifdef DOUBLE_BUF_EN
            act     <= ~act;
`endif
          end
        end
        STREAM: begin
          if (!bus.stall) begin
            if (col_cnt == CW'(N - 1)) begin
              if (N > 1) begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!bus.stall && (flush_cnt != CW'(N - 2))) begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase

`ifdef DOUBLE_BUF_EN
      if ((state != LOAD) && last_beat) begin
        shadow_full <= 1'b1;
        rdy         <= 1'b0;
      end
`endif

      if (tile_end) begin
        done_q <= 1'b1;
        rdy    <= 1'b1;
`ifdef DOUBLE_BUF_EN
        if (next_ready) begin
          state       <= STREAM;
          col_cnt     <= '0;
          act         <= ~act;
          shadow_full <= 1'b0;
        end else begin
          state <= LOAD;
        end
`else
        state <= LOAD;
`endif
      end
    end
  end

  // Row r of the active buffer contributes its element k to slice r of the column.
  always_comb begin
    col = '0;
    if (state == STREAM) begin
      for (int r = 0; r < N; r++) begin
        col[r*D_W +: D_W] = mem[act][r][col_cnt*D_W +: D_W];
      end
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_data   = col;
  assign bus.out_enable = (state != LOAD) & ~bus.stall;
  assign bus.out_first  = (state == STREAM) && (col_cnt == '0);
  assign bus.out_last   = (state == STREAM) && (col_cnt == CW'(N - 1));
  assign bus.busy       = (state != LOAD);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_tile_column_feeder.sv
// Scoreboarded bench for tile_column_feeder: stimulus pushes expected column/done events, a negedge monitor pops and compares.
// Covers the DOUBLE_BUF_EN back-to-back tile case when that macro is defined.
module tb_tile_column_feeder;
  localparam int N   = 4;
  localparam int D_W = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic        en;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_column_feeder_if #(.N(N), .D_W(D_W)) bus();
  tile_column_feeder #(.N(N), .D_W(D_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t        sb[$];
  obs_t        mon_o;
  obs_t        mon_e;
  int          nvec = 0;
  int          nmis = 0;
  int          done_cnt = 0;
  logic [31:0] cols [4] = '{32'h0D090501, 32'h0E0A0602, 32'h0F0B0703, 32'h100C0804};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && (bus.out_enable === 1'b1 || bus.done === 1'b1)) begin
      mon_o = '{bus.out_data, bus.out_first, bus.out_last, bus.out_enable, bus.done};
      if (bus.done === 1'b1) done_cnt++;
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_output: got %h expected nothing at %0t", mon_o, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("stream", 64'(mon_o), 64'(mon_e));
      end
    end
  end

  // Expected: 4 columns, 3 enabled zero columns, optional done-only cycle.
  task automatic push_tile(input logic [31:0] off, input logic first_done, input logic tail_done);
    obs_t e;
    for (int k = 0; k < 4; k++) begin
      e = '{cols[k] + off * 32'h01010101, (k == 0), (k == 3), 1'b1, (k == 0) & first_done};
      sb.push_back(e);
    end
    for (int z = 0; z < 3; z++) begin
      e = '{32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      sb.push_back(e);
    end
    if (tail_done) begin
      e = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
      sb.push_back(e);
    end
  endtask

  task automatic send_tile(input int off, input int gap);
    logic [31:0] row;
    int          guard;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) row[c*D_W +: D_W] = 8'(4 * r + c + 1 + off);
      bus.in_valid = 1'b1;
      bus.in_data  = row;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (bus.in_ready !== 1'b1 && guard < 100);
      if (guard >= 100) begin
        nvec++;
        nmis++;
        $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 100 cycles", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (gap > 0 && r < N - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    nmis++;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.stall    = 1'b0;
    #1;
    chk("reset_outputs", 64'({bus.in_ready, bus.out_enable, bus.out_first, bus.out_last,
                              bus.busy, bus.done, bus.out_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 64'({bus.in_ready, bus.out_enable, bus.busy, bus.done, bus.out_data}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'(1));

    // Basic back-to-back tile with latency and done timing.
    push_tile(32'd0, 1'b0, 1'b1);
    send_tile(0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("first_latency", 64'({bus.out_first, bus.out_enable}), 64'(2'b11));
`ifndef DOUBLE_BUF_EN
      if (i == 1) chk("no_ready_in_stream", 64'(bus.in_ready), 64'(0));
`endif
      if (i == 6) chk("last_zero_enabled", 64'({bus.out_enable, bus.busy, bus.out_data}), 64'({2'b11, 32'h0}));
      if (i == 7) chk("done_and_ready", 64'({bus.done, bus.in_ready, bus.busy}), 64'(3'b110));
    end
    wait_drain();

    // Alternating-cycle beats.
    push_tile(32'd0, 1'b0, 1'b1);
    send_tile(0, 1);
    @(negedge clk);
    chk("gap_first_latency", 64'({bus.out_first, bus.out_enable, bus.out_data}), 64'({2'b11, 32'h0D090501}));
    wait_drain();

    // Stall for 3 cycles while column 1 is presented.
    push_tile(32'd0, 1'b0, 1'b1);
    send_tile(0, 0);
    @(posedge clk);
    #1;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({bus.out_enable, bus.out_first, bus.out_last, bus.out_data}),
          64'({3'b000, 32'h0E0A0602}));
      @(posedge clk);
    end
    #1;
    bus.stall = 1'b0;
    wait_drain();

    // Stall on the final flush cycle defers done by the stall length.
    push_tile(32'd0, 1'b0, 1'b1);
    send_tile(0, 0);
    repeat (6) @(posedge clk);
    #1;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_stall", 64'({bus.out_enable, bus.done, bus.busy, bus.out_data}), 64'({3'b001, 32'h0}));
      @(posedge clk);
    end
    #1;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("flush_resume", 64'({bus.out_enable, bus.done}), 64'(2'b10));
    @(negedge clk);
    chk("done_deferred", 64'({bus.out_enable, bus.done}), 64'(2'b01));
    wait_drain();

    // Reset while column 2 is presented, then a fresh tile.
    push_tile(32'd0, 1'b0, 1'b1);
    send_tile(0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 64'({bus.in_ready, bus.out_enable, bus.out_first, bus.out_last,
                                 bus.busy, bus.done, bus.out_data}), 64'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", 64'(bus.in_ready), 64'(1));
    push_tile(32'd16, 1'b0, 1'b1);
    send_tile(16, 0);
    wait_drain();

`ifdef DOUBLE_BUF_EN
    // Two tiles back to back: second tile starts right after the first flush with done.
    d0 = done_cnt;
    push_tile(32'd0, 1'b0, 1'b0);
    push_tile(32'd16, 1'b1, 1'b1);
    send_tile(0, 0);
    send_tile(16, 0);
    wait_drain();
    chk("double_done_pulses", 64'(done_cnt - d0), 64'(2));
`else
    d0 = done_cnt;
    chk("done_count_stable", 64'(done_cnt - d0), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/tile_column_feeder.md
Name: tile_column_feeder

Overview:
Upstream operand stage for the systolic-array matrix multiply. Accepts an NxN operand tile row-by-row over a valid/ready stream and holds it in a local tile buffer. Replays the tile one column per cycle into the skew stage, driving that stage's enable, then issues N-1 zero columns so the skewed rows drain. Signals tile boundaries and completion to the array controller.

Parameters:
N, 4, array dimension (rows/cols per tile, elements per beat)
D_W, 8, element width in bits

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream row beat valid
in_ready  output  1  feeder can accept a row beat
in_data  input  N*D_W  one tile row; slice [c*D_W +: D_W] = A[row][c]
stall  input  1  downstream hold; freezes streaming/flush progress
out_data  output  N*D_W  column to skew stage; slice [r*D_W +: D_W] = A[r][k]
out_enable  output  1  enable for skew stage
out_first  output  1  high while column k=0 presented
out_last  output  1  high while column k=N-1 presented
busy  output  1  high in STREAM or FLUSH
done  output  1  one-cycle pulse when flush completes

Behaviour:
- Reset (reset low, async): state LOAD, row/column/flush counters 0, buffer contents 0. While reset low: in_ready=0, out_data=0, out_enable=0, out_first=0, out_last=0, busy=0, done=0.
- States: LOAD, STREAM, FLUSH. done is a registered pulse in the cycle after the FLUSH exit.
- LOAD: in_ready=1. Each beat with in_valid&in_ready writes in_data into buffer row row_cnt; row_cnt increments. Gaps in in_valid simply wait. On the beat with row_cnt=N-1: row_cnt<=0, state<=STREAM, col_cnt<=0.
- STREAM: in_ready=0 (without DOUBLE_BUF_EN). out_data = column col_cnt of the buffer. out_enable = !stall. col_cnt advances only when !stall. out_first = (col_cnt==0), out_last = (col_cnt==N-1). Both are independent of stall. When col_cnt=N-1 and !stall: state<=FLUSH, flush_cnt<=0.
- FLUSH: out_data=0, out_enable=!stall, out_first=out_last=0. flush_cnt advances when !stall. When flush_cnt=N-2 and !stall: state<=LOAD, done pulses next cycle. For N=1, FLUSH is skipped: STREAM goes directly to LOAD and done pulses.
- Latency: the first column is presented in the cycle after the last row beat is accepted. Minimum STREAM+FLUSH span is 2N-1 enabled cycles.
- Stall: stall is ignored in LOAD. Stall holds out_data and all counters, and forces out_enable=0. It can be asserted on any cycle, including the last STREAM or FLUSH cycle; the transition is then deferred.
- Outputs outside STREAM/FLUSH: out_data=0, out_enable=0.
- busy = (state==STREAM)|(state==FLUSH).
- Mid-operation reset: asynchronously aborts to the reset values above. A partially loaded tile is discarded.

Optional Feature:
DOUBLE_BUF_EN
- Defined: two tile buffers (active/shadow). in_ready=1 whenever the shadow buffer is not full, including during STREAM and FLUSH. Loading into the shadow proceeds in parallel with streaming.
  - At FLUSH exit (or STREAM exit when N=1), if the shadow is full: buffers swap, state goes directly to STREAM with col_cnt=0, and done still pulses. Zero idle cycles between tiles.
  - If the shadow is not full, the feeder enters LOAD and continues filling it.
- Undefined: single buffer, in_ready=0 outside LOAD, exactly as above.

Test Plan:
- Basic tile, N=4, D_W=8, A[r][c]=4r+c+1, four beats back-to-back (row0 in_data=32'h04030201) -> out_data on successive enabled cycles:
  - 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703, 32'h100C0804
  - then 3 cycles of 32'h0 with out_enable=1
  - out_first on cycle 1, out_last on cycle 4, done pulse one cycle after the 3rd zero column, in_ready=1 again.
- in_valid gaps (valid on alternating cycles) -> same output sequence; STREAM starts the cycle after the 4th accepted beat.
- stall high for 3 cycles while col_cnt=1 -> out_enable=0 and out_data held at 32'h0E0A0602 for those cycles, then the sequence resumes unchanged.
- stall asserted on the last FLUSH cycle -> done delayed by the stall length; out_data stays 0.
- reset low during STREAM at col_cnt=2 -> all outputs 0 immediately. After release: in_ready=1, a new tile streams correctly with no stale data.
- DOUBLE_BUF_EN, two tiles sent continuously (second tile B[r][c]=A[r][c]+16) -> second tile's first column 32'h1D191511 appears in the cycle after the first tile's last zero column; done pulses twice.
